// File: rtl/cga_pkg.sv
// Shared timing defaults, lock-state encoding and RGBI bit positions for the
// CGA transmitter.
package cga_pkg;

    localparam int unsigned CGA_PE_INC       = 32'd18767;
    localparam int unsigned CGA_ACC_W        = 32'd16;
    localparam int unsigned CGA_H_TOTAL      = 32'd912;
    localparam int unsigned CGA_H_ACTIVE     = 32'd640;
    localparam int unsigned CGA_H_SYNC_START = 32'd720;
    localparam int unsigned CGA_H_SYNC_LEN   = 32'd64;
    localparam int unsigned CGA_V_TOTAL      = 32'd262;
    localparam int unsigned CGA_V_ACTIVE     = 32'd200;
    localparam int unsigned CGA_V_SYNC_START = 32'd224;
    localparam int unsigned CGA_V_SYNC_LEN   = 32'd3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } lock_state_e;

    localparam int unsigned RGBI_R = 32'd3;
    localparam int unsigned RGBI_G = 32'd2;
    localparam int unsigned RGBI_B = 32'd1;
    localparam int unsigned RGBI_I = 32'd0;

endpackage

// File: rtl/cga_tx_if.sv
// Pixel stream into the CGA transmitter: {R,G,B,I} head pixel with
// start-of-frame flag and a valid/ready handshake.
interface cga_tx_if;

    logic [3:0] pix_data;
    logic       pix_sof;
    logic       pix_valid;
    logic       pix_ready;

    modport master (
        output pix_data,
        output pix_sof,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_sof,
        input  pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/cga_timing.sv
// Dot-enable phase accumulator plus free-running raster counters; decodes the
// active window, both syncs and the frame-start dot for the current position.
module cga_timing
    import cga_pkg::*;
#(
    parameter int unsigned PE_INC       = CGA_PE_INC,
    parameter int unsigned ACC_W        = CGA_ACC_W,
    parameter int unsigned H_TOTAL      = CGA_H_TOTAL,
    parameter int unsigned H_ACTIVE     = CGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = CGA_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN   = CGA_H_SYNC_LEN,
    parameter int unsigned V_TOTAL      = CGA_V_TOTAL,
    parameter int unsigned V_ACTIVE     = CGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = CGA_V_SYNC_START,
    parameter int unsigned V_SYNC_LEN   = CGA_V_SYNC_LEN,
    parameter int unsigned HCNT_W       = $clog2(H_TOTAL),
    parameter int unsigned VCNT_W       = $clog2(V_TOTAL)
) (
    input  logic clk,
    input  logic rst_n,
    output logic pe,
    output logic active,
    output logic hs,
    output logic vs,
    output logic fs
);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W:0]    acc_sum_s;
    logic [HCNT_W-1:0] hcnt_q;
    logic [HCNT_W-1:0] hcnt_d;
    logic [VCNT_W-1:0] vcnt_q;
    logic [VCNT_W-1:0] vcnt_d;

    // The dot enable is simply the carry out of the phase accumulator.
    assign acc_sum_s = {1'b0, acc_q} + (ACC_W + 1)'(PE_INC);
    assign pe        = acc_sum_s[ACC_W];

    // Next accumulator phase and raster position; counters move only on a dot.
    always_comb begin
        acc_d  = acc_sum_s[ACC_W-1:0];
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pe) begin
            if (hcnt_q == HCNT_W'(H_TOTAL - 32'd1)) begin
                hcnt_d = HCNT_W'(0);
                if (vcnt_q == VCNT_W'(V_TOTAL - 32'd1)) begin
                    vcnt_d = VCNT_W'(0);
                end else begin
                    vcnt_d = vcnt_q + VCNT_W'(1);
                end
            end else begin
                hcnt_d = hcnt_q + HCNT_W'(1);
                vcnt_d = vcnt_q;
            end
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end
    end

    // Accumulator and raster counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= ACC_W'(0);
            hcnt_q <= HCNT_W'(0);
            vcnt_q <= VCNT_W'(0);
        end else begin
            acc_q  <= acc_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign active = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    assign hs     = (32'(hcnt_q) >= H_SYNC_START) &&
                    (32'(hcnt_q) <  (H_SYNC_START + H_SYNC_LEN));
    assign vs     = (32'(vcnt_q) >= V_SYNC_START) &&
                    (32'(vcnt_q) <  (V_SYNC_START + V_SYNC_LEN));
    assign fs     = (hcnt_q == HCNT_W'(0)) && (vcnt_q == VCNT_W'(0));

endmodule

// File: rtl/cga_tx.sv
// CGA transmitter top: locks the incoming pixel stream to the free-running
// raster on its SOF flag and drives registered RGBI and H/V sync outputs.
module cga_tx
    import cga_pkg::*;
#(
    parameter int unsigned PE_INC       = CGA_PE_INC,
    parameter int unsigned ACC_W        = CGA_ACC_W,
    parameter int unsigned H_TOTAL      = CGA_H_TOTAL,
    parameter int unsigned H_ACTIVE     = CGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = CGA_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN   = CGA_H_SYNC_LEN,
    parameter int unsigned V_TOTAL      = CGA_V_TOTAL,
    parameter int unsigned V_ACTIVE     = CGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = CGA_V_SYNC_START,
    parameter int unsigned V_SYNC_LEN   = CGA_V_SYNC_LEN
) (
    input  logic     CLK50M,
    input  logic     RESET_N,
    cga_tx_if.slave  pix,
    input  logic     CLR_ERR,
    output logic     CGA_R,
    output logic     CGA_G,
    output logic     CGA_B,
    output logic     CGA_I,
    output logic     CGA_H,
    output logic     CGA_V,
    output logic     LOCKED,
    output logic     UNDERRUN,
    output logic     MISALIGN
);

    logic        pe_s;
    logic        active_s;
    logic        hs_s;
    logic        vs_s;
    logic        fs_s;

    lock_state_e state_q;
    lock_state_e state_d;
    logic        ready_s;
    logic        take_s;
    logic        und_set_s;
    logic        mis_set_s;

    logic [3:0]  rgbi_q;
    logic [3:0]  rgbi_d;
    logic        hsync_q;
    logic        hsync_d;
    logic        vsync_q;
    logic        vsync_d;
    logic        locked_q;
    logic        locked_d;
    logic        underrun_q;
    logic        underrun_d;
    logic        misalign_q;
    logic        misalign_d;

    cga_timing #(
        .PE_INC       (PE_INC),
        .ACC_W        (ACC_W),
        .H_TOTAL      (H_TOTAL),
        .H_ACTIVE     (H_ACTIVE),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_LEN   (H_SYNC_LEN),
        .V_TOTAL      (V_TOTAL),
        .V_ACTIVE     (V_ACTIVE),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_LEN   (V_SYNC_LEN)
    ) u_timing (
        .clk    (CLK50M),
        .rst_n  (RESET_N),
        .pe     (pe_s),
        .active (active_s),
        .hs     (hs_s),
        .vs     (vs_s),
        .fs     (fs_s)
    );

    // Lock FSM and stream handshake. In WAIT the held SOF pixel is taken on
    // the frame-start dot; if it has gone invalid by then we still enter RUN.
    always_comb begin
        state_d   = state_q;
        ready_s   = 1'b0;
        take_s    = 1'b0;
        und_set_s = 1'b0;
        mis_set_s = 1'b0;
        case (state_q)
            HUNT: begin
                ready_s = pix.pix_valid & ~pix.pix_sof;
                if (pix.pix_valid && pix.pix_sof) begin
                    state_d = WAIT;
                end else begin
                    state_d = HUNT;
                end
            end
            WAIT: begin
                if (pe_s && fs_s) begin
                    state_d = RUN;
                    ready_s = pix.pix_valid & pix.pix_sof;
                    take_s  = pix.pix_valid & pix.pix_sof;
                end else begin
                    state_d = WAIT;
                end
            end
            RUN: begin
                if (pe_s && active_s) begin
                    if (!pix.pix_valid) begin
                        und_set_s = 1'b1;
                    end else if (pix.pix_sof == fs_s) begin
                        ready_s = 1'b1;
                        take_s  = 1'b1;
                    end else begin
                        mis_set_s = 1'b1;
                        state_d   = HUNT;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    assign pix.pix_ready = ready_s;

    // Output and flag next values; video outputs refresh only on dot cycles.
    always_comb begin
        rgbi_d  = rgbi_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pe_s) begin
            rgbi_d  = take_s ? pix.pix_data : 4'b0000;
            hsync_d = hs_s;
            vsync_d = vs_s;
        end else begin
            rgbi_d  = rgbi_q;
            hsync_d = hsync_q;
            vsync_d = vsync_q;
        end
        locked_d   = (state_d == RUN);
        underrun_d = und_set_s ? 1'b1 : (CLR_ERR ? 1'b0 : underrun_q);
        misalign_d = mis_set_s ? 1'b1 : (CLR_ERR ? 1'b0 : misalign_q);
    end

    // State, video output and sticky flag registers.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= HUNT;
            rgbi_q     <= 4'b0000;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            locked_q   <= 1'b0;
            underrun_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rgbi_q     <= rgbi_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            locked_q   <= locked_d;
            underrun_q <= underrun_d;
            misalign_q <= misalign_d;
        end
    end

    assign CGA_R    = rgbi_q[RGBI_R];
    assign CGA_G    = rgbi_q[RGBI_G];
    assign CGA_B    = rgbi_q[RGBI_B];
    assign CGA_I    = rgbi_q[RGBI_I];
    assign CGA_H    = hsync_q;
    assign CGA_V    = vsync_q;
    assign LOCKED   = locked_q;
    assign UNDERRUN = underrun_q;
    assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_cga_tx.sv
// Randomized bench for cga_tx on a shrunken raster; every cycle is compared
// against a dot-index reference model of the lock/handshake rules.
module tb_cga_tx;

    localparam int PE_INC = 18767;
    localparam int ACC_W  = 16;
    localparam int HT     = 24;
    localparam int HA     = 16;
    localparam int HSS    = 18;
    localparam int HSL    = 3;
    localparam int VT     = 12;
    localparam int VA     = 8;
    localparam int VSS    = 9;
    localparam int VSL    = 2;
    localparam int NPIX   = HA * VA;
    localparam int FRAME_CLK = 1100;
    localparam int M_HUNT = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;

    logic clk;
    logic rst_n;
    logic clr_err;
    logic cga_r, cga_g, cga_b, cga_i, cga_h, cga_v;
    logic locked, underrun, misalign;

    cga_tx_if pix_if();

    cga_tx #(
        .PE_INC(PE_INC), .ACC_W(ACC_W),
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .CLK50M   (clk),
        .RESET_N  (rst_n),
        .pix      (pix_if),
        .CLR_ERR  (clr_err),
        .CGA_R    (cga_r),
        .CGA_G    (cga_g),
        .CGA_B    (cga_b),
        .CGA_I    (cga_i),
        .CGA_H    (cga_h),
        .CGA_V    (cga_v),
        .LOCKED   (locked),
        .UNDERRUN (underrun),
        .MISALIGN (misalign)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] src_q[$];
    bit src_en, gap_en, rnd_gap;
    int gap_v, gap_h0;

    // reference model state: position is a plain dot index since reset
    int unsigned m_acc;
    int          m_dot;
    int          m_st;
    logic [3:0]  m_rgbi;
    logic        m_h, m_v, m_lock, m_und, m_mis;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_dot = 0; m_st = M_HUNT;
        m_rgbi = 4'b0000; m_h = 1'b0; m_v = 1'b0;
        m_lock = 1'b0; m_und = 1'b0; m_mis = 1'b0;
    endtask

    task automatic check_outs();
        check_eq("rgbi",     {28'd0, cga_r, cga_g, cga_b, cga_i}, {28'd0, m_rgbi});
        check_eq("hsync",    cga_h,    m_h);
        check_eq("vsync",    cga_v,    m_v);
        check_eq("locked",   locked,   m_lock);
        check_eq("underrun", underrun, m_und);
        check_eq("misalign", misalign, m_mis);
    endtask

    function automatic void push_frame(input int drop_idx, input int sof_idx);
        for (int i = 0; i < NPIX; i++) begin
            if (i != drop_idx)
                src_q.push_back({(i == 0 || i == sof_idx) ? 1'b1 : 1'b0, 4'($urandom)});
        end
    endfunction

    function automatic int first_sof();
        for (int i = 0; i < src_q.size(); i++)
            if (src_q[i][4]) return i;
        return -1;
    endfunction

    // One clock: drive inputs, check ready, advance model, check outputs.
    task automatic step();
        bit val, sof, hold, head_sof, pe, act, hs_m, vs_m, fs_m;
        bit rdy, take, und_set, mis_set;
        logic [3:0] dat;
        int h, v, nst;
        h = m_dot % HT;
        v = m_dot / HT;
        head_sof = 1'b0;
        if (src_q.size() > 0) head_sof = src_q[0][4];
        hold = gap_en && (v == gap_v) && (h >= gap_h0) && (h < gap_h0 + 5);
        if (rnd_gap && !head_sof && ($urandom_range(0, 5) == 0)) hold = 1'b1;
        val = src_en && !hold && (src_q.size() > 0);
        sof = 1'b0;
        dat = 4'h0;
        if (val) begin
            sof = src_q[0][4];
            dat = src_q[0][3:0];
        end
        pix_if.pix_valid = val;
        pix_if.pix_sof   = sof;
        pix_if.pix_data  = dat;
        #1;
        pe   = (m_acc + PE_INC) >= (32'd1 << ACC_W);
        act  = (h < HA) && (v < VA);
        hs_m = (h >= HSS) && (h < HSS + HSL);
        vs_m = (v >= VSS) && (v < VSS + VSL);
        fs_m = (m_dot == 0);
        rdy = 0; take = 0; und_set = 0; mis_set = 0; nst = m_st;
        if (m_st == M_HUNT) begin
            rdy = val && !sof;
            if (val && sof) nst = M_WAIT;
        end else if (m_st == M_WAIT) begin
            if (pe && fs_m) begin
                nst = M_RUN;
                rdy = val && sof;
                take = rdy;
            end
        end else if (pe && act) begin
            if (!val) und_set = 1;
            else if (sof == fs_m) begin rdy = 1; take = 1; end
            else begin mis_set = 1; nst = M_HUNT; end
        end
        check_eq("pix_ready", pix_if.pix_ready, rdy);
        if (pe) begin
            m_rgbi = take ? dat : 4'b0000;
            m_h = hs_m;
            m_v = vs_m;
        end
        m_und  = und_set ? 1'b1 : (clr_err ? 1'b0 : m_und);
        m_mis  = mis_set ? 1'b1 : (clr_err ? 1'b0 : m_mis);
        m_st   = nst;
        m_lock = (nst == M_RUN);
        m_acc  = (m_acc + PE_INC) % (32'd1 << ACC_W);
        if (pe) m_dot = (m_dot + 1) % (HT * VT);
        // an upstream that misses a dot skips that pixel to stay aligned
        if (rdy) void'(src_q.pop_front());
        else if (hold && pe && act && src_q.size() > 0 && !head_sof) void'(src_q.pop_front());
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic run_frames(input int k);
        int wraps, guard, prev;
        wraps = 0; guard = 0;
        while (wraps < k && guard < k * FRAME_CLK * 2) begin
            prev = m_dot;
            step();
            if (m_dot == 0 && prev != 0) wraps++;
            guard++;
        end
        check_eq("frame_budget", wraps, k);
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin
        int idx;
        src_en = 0; gap_en = 0; rnd_gap = 0; gap_v = 0; gap_h0 = 0;
        clr_err = 1'b0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_sof   = 1'b0;
        pix_if.pix_data  = 4'h0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // idle raster: syncs run, nothing locks
        run_frames(2);

        // garbage then a steady supply of SOF-led frames
        repeat (3) src_q.push_back({1'b0, 4'($urandom)});
        for (int f = 0; f < 12; f++) push_frame(-1, -1);
        src_en = 1;
        run_frames(2);
        check_eq("lock_locked",   locked,   1);
        check_eq("lock_underrun", underrun, 0);
        check_eq("lock_misalign", misalign, 0);

        // five missing pixels on line 2
        gap_en = 1; gap_v = 2; gap_h0 = 3;
        run_frames(1);
        gap_en = 0;
        check_eq("gap_underrun", underrun, 1);
        check_eq("gap_locked",   locked,   1);
        clr_pulse();
        check_eq("gap_cleared",  underrun, 0);

        // stray SOF mid-frame at (5,4)
        idx = first_sof();
        src_q[idx + 4 * HA + 5][4] = 1'b1;
        run_frames(1);
        check_eq("sof_misalign", misalign, 1);
        check_eq("sof_unlocked", locked,   0);
        run_frames(2);
        check_eq("sof_relocked", locked,   1);
        clr_pulse();
        check_eq("sof_cleared",  misalign, 0);

        // one pixel lost: next SOF lands on the last active dot
        idx = first_sof();
        src_q.delete(idx + 10);
        run_frames(1);
        check_eq("drop_misalign", misalign, 1);
        check_eq("drop_unlocked", locked,   0);
        run_frames(1);
        check_eq("drop_relocked", locked,   1);
        clr_pulse();

        // random upstream gaps
        rnd_gap = 1;
        run_frames(1);
        rnd_gap = 0;
        check_eq("rnd_locked", locked, 1);
        clr_pulse();

        // asynchronous reset in the middle of a line
        repeat (300) step();
        #5 rst_n = 1'b0;
        pix_if.pix_valid = 1'b0;
        model_reset();
        #1;
        check_outs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(2);
        check_eq("reset_relocked", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
